// File: rtl/spio_hss_multiplexer_pkg.sv
// Shared constants and types for the HSS multiplexer TX scheduler.
package spio_hss_multiplexer_pkg;
  localparam int NUM_CHANS = 8;
  localparam int CHAN_BITS = 3;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } sched_state_e;
endpackage

// File: rtl/spio_hss_multiplexer_rr_arbiter.sv
// 8-way rotating-priority arbiter, purely combinational.
module spio_hss_multiplexer_rr_arbiter
  import spio_hss_multiplexer_pkg::*;
(
  input  logic [NUM_CHANS-1:0] req_i,
  input  logic [CHAN_BITS-1:0] ptr_i,
  input  logic                 en_i,
  output logic [NUM_CHANS-1:0] gnt_o,
  output logic [CHAN_BITS-1:0] idx_o
);

  logic                 hit;
  logic [CHAN_BITS-1:0] c;

  // Walk from the far end so the nearest requester to ptr wins.
  always_comb begin
    hit   = 1'b0;
    idx_o = '0;
    c     = '0;
    for (int i = NUM_CHANS - 1; i >= 0; i--) begin
      c = ptr_i + CHAN_BITS'(i);
      if (req_i[c]) begin
        hit   = 1'b1;
        idx_o = c;
      end
    end
  end

  assign gnt_o = (en_i && hit) ? (NUM_CHANS'(1) << idx_o) : '0;

endmodule

// File: rtl/spio_hss_multiplexer_pkt_scheduler.sv
// HSS TX packet scheduler: RR grant, frame grouping, timeout/link close.
// SPIO_HSS_SCHED_PRIORITY_EN gives channel 0 strict priority.
module spio_hss_multiplexer_pkt_scheduler
  import spio_hss_multiplexer_pkg::*;
#(
  parameter int PKT_BITS       = 72,
  parameter int MAX_FRAME_PKTS = 8,
  parameter int FRAME_TIMEOUT  = 16
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic                          LINK_UP_IN,
  input  logic [NUM_CHANS*PKT_BITS-1:0] PKT_DATA_IN,
  input  logic [NUM_CHANS-1:0]          PKT_VLD_IN,
  output logic [NUM_CHANS-1:0]          PKT_RDY_OUT,
  input  logic [NUM_CHANS-1:0]          CHAN_STOP_IN,
  output logic [PKT_BITS-1:0]           SCHED_DATA_OUT,
  output logic [CHAN_BITS-1:0]          SCHED_CHAN_OUT,
  output logic                          SCHED_LAST_OUT,
  output logic                          SCHED_CLOSE_OUT,
  output logic                          SCHED_VLD_OUT,
  input  logic                          SCHED_RDY_IN,
  output logic [15:0]                   FRAME_CNT_OUT
);

  localparam logic [7:0] TO_MAX  = 8'(FRAME_TIMEOUT - 1);
  localparam logic [7:0] PKT_MAX = 8'(MAX_FRAME_PKTS);

  sched_state_e         state_q;
  logic [CHAN_BITS-1:0] ptr_q;
  logic [7:0]           pkt_cnt_q, pkt_cnt_d, idle_cnt_q;
  logic [15:0]          fcnt_q;
  logic                 vld_q, last_q, close_q;
  logic [CHAN_BITS-1:0] chan_q;
  logic [PKT_BITS-1:0]  data_q;

  logic [NUM_CHANS-1:0] elig_w, rr_gnt_w, gnt_w;
  logic [CHAN_BITS-1:0] rr_idx_w, idx_w;
  logic                 slot_free_w, en_w, pri_w, take_w;
  logic                 xfer_w, pkt_last_w, close_w;
  logic [PKT_BITS-1:0]  gdata_w;

  assign elig_w      = PKT_VLD_IN & ~CHAN_STOP_IN;
  assign slot_free_w = ~vld_q | SCHED_RDY_IN;
  assign xfer_w      = vld_q & SCHED_RDY_IN;
  assign en_w        = LINK_UP_IN & slot_free_w & RESET_IN;

  spio_hss_multiplexer_rr_arbiter u_arb (
    .req_i (elig_w),
    .ptr_i (ptr_q),
    .en_i  (en_w),
    .gnt_o (rr_gnt_w),
    .idx_o (rr_idx_w)
  );

`ifdef SPIO_HSS_SCHED_PRIORITY_EN
  assign pri_w = en_w & elig_w[0];
`else
  assign pri_w = 1'b0;
`endif

  assign gnt_w   = pri_w ? NUM_CHANS'(1) : rr_gnt_w;
  assign idx_w   = pri_w ? '0 : rr_idx_w;
  assign take_w  = |gnt_w;
  assign gdata_w = PKT_DATA_IN[idx_w*PKT_BITS +: PKT_BITS];

  assign pkt_cnt_d  = (state_q == ST_OPEN) ? pkt_cnt_q + 8'd1 : 8'd1;
  assign pkt_last_w = (pkt_cnt_d == PKT_MAX);
  // Link loss and timeout both end the frame with an empty beat.
  assign close_w    = slot_free_w & (~LINK_UP_IN | (idle_cnt_q == TO_MAX));

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      pkt_cnt_q  <= '0;
      idle_cnt_q <= '0;
      fcnt_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      close_q    <= 1'b0;
      chan_q     <= '0;
      data_q     <= '0;
    end else begin
      if (xfer_w) begin
        vld_q <= 1'b0;
        if (last_q) fcnt_q <= fcnt_q + 16'd1;
      end
      if (take_w && !pri_w) ptr_q <= idx_w + CHAN_BITS'(1);
      if (take_w) begin
        vld_q      <= 1'b1;
        data_q     <= gdata_w;
        chan_q     <= idx_w;
        close_q    <= 1'b0;
        last_q     <= pkt_last_w;
        pkt_cnt_q  <= pkt_cnt_d;
        idle_cnt_q <= '0;
        state_q    <= pkt_last_w ? ST_IDLE : ST_OPEN;
      end else if (state_q == ST_OPEN) begin
        if (close_w) begin
          vld_q   <= 1'b1;
          data_q  <= '0;
          chan_q  <= '0;
          close_q <= 1'b1;
          last_q  <= 1'b1;
          state_q <= ST_IDLE;
        end else if (idle_cnt_q != TO_MAX) begin
          idle_cnt_q <= idle_cnt_q + 8'd1;
        end
      end
    end
  end

  assign PKT_RDY_OUT     = gnt_w;
  assign SCHED_DATA_OUT  = data_q;
  assign SCHED_CHAN_OUT  = chan_q;
  assign SCHED_LAST_OUT  = last_q;
  assign SCHED_CLOSE_OUT = close_q;
  assign SCHED_VLD_OUT   = vld_q;
  assign FRAME_CNT_OUT   = fcnt_q;

endmodule
